// File: rtl/xor_share_arbiter.sv
// xor_share_arbiter: round-robin time-sharing of one registered XOR datapath between NREQ requesters
// Ports: clk, rst (async, active-high); req[NREQ] level requests held until ack;
//   a_bus/b_bus packed operands (requester i at [i*WIDTH +: WIDTH]);
//   ack one-hot one-cycle completion; result = a^b of acked op; result_id = acked index;
//   busy high in EXEC and RESP.
// Optional: define XOR_SHARE_STATS_EN to add op_count[15:0], a wrapping count of completed ops.
module xor_share_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] a_bus,
  input  logic [NREQ*WIDTH-1:0] b_bus,
`ifdef XOR_SHARE_STATS_EN
  output logic [15:0]           op_count,
`endif
  output logic [NREQ-1:0]       ack,
  output logic [WIDTH-1:0]      result,
  output logic [IDW-1:0]        result_id,
  output logic                  busy
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  logic [1:0]       r_state;
  logic [IDW-1:0]   r_ptr;
  logic [IDW-1:0]   r_id;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [NREQ-1:0]  r_ack;
  logic [WIDTH-1:0] r_result;
  logic [IDW-1:0]   r_result_id;
  logic             r_busy;
  logic [IDW:0]     w_j;
  logic [IDW-1:0]   w_win;
  logic [IDW-1:0]   w_ptr_nxt;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [NREQ-1:0]  w_onehot;
  // Scan from the farthest offset down to rr_ptr so the closest set request wins last.
  always_comb begin
    w_win = '0;
    w_j = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_j = {1'b0, r_ptr} + (IDW+1)'(k);
      w_j = (w_j >= (IDW+1)'(NREQ)) ? w_j - (IDW+1)'(NREQ) : w_j;
      w_win = req[w_j[IDW-1:0]] ? w_j[IDW-1:0] : w_win;
    end
  end
  assign w_ptr_nxt = (w_win == IDW'(NREQ - 1)) ? '0 : w_win + 1'b1;
  assign w_a = a_bus[int'(w_win)*WIDTH +: WIDTH];
  assign w_b = b_bus[int'(w_win)*WIDTH +: WIDTH];
  assign w_onehot = {{(NREQ-1){1'b0}}, 1'b1} << r_id;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_id        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_ack       <= '0;
      r_result    <= '0;
      r_result_id <= '0;
      r_busy      <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (|req) begin
        r_a     <= w_a;
        r_b     <= w_b;
        r_id    <= w_win;
        r_ptr   <= w_ptr_nxt;
        r_busy  <= 1'b1;
        r_state <= S_EXEC;
      end
    end else if (r_state == S_EXEC) begin
      r_result    <= r_a ^ r_b;
      r_result_id <= r_id;
      r_ack       <= w_onehot;
      r_state     <= S_RESP;
    end else begin
      r_ack   <= '0;
      r_busy  <= 1'b0;
      r_state <= S_IDLE;
    end
  end
`ifdef XOR_SHARE_STATS_EN
  logic [15:0] r_count;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_count <= '0;
    else if (r_state == S_RESP) r_count <= r_count + 16'd1;
  end
  assign op_count = r_count;
`endif
  assign ack       = r_ack;
  assign result    = r_result;
  assign result_id = r_result_id;
  assign busy      = r_busy;
endmodule

// File: tb/tb_xor_share_arbiter.sv
// tb_xor_share_arbiter: directed self-checking bench for xor_share_arbiter
module tb_xor_share_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] a_bus;
  logic [31:0] b_bus;
  logic [3:0]  ack;
  logic [7:0]  result;
  logic [1:0]  result_id;
  logic        busy;
  int          errors = 0;
  int          checks = 0;
`ifdef XOR_SHARE_STATS_EN
  logic [15:0] op_count;
`endif
  xor_share_arbiter #(.NREQ(4), .WIDTH(8), .IDW(2)) dut (
    .clk(clk),
    .rst(rst),
    .req(req),
    .a_bus(a_bus),
    .b_bus(b_bus),
`ifdef XOR_SHARE_STATS_EN
    .op_count(op_count),
`endif
    .ack(ack),
    .result(result),
    .result_id(result_id),
    .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // Expect a completed op in the current (RESP) cycle.
  task automatic chk_op(input string tag, input logic [1:0] id, input logic [7:0] res);
    logic [3:0] oh;
    oh = 4'b0001 << id;
    chk({tag, "_ack"}, 32'(ack), 32'(oh));
    chk({tag, "_result"}, 32'(result), 32'(res));
    chk({tag, "_id"}, 32'(result_id), 32'(id));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
  endtask
  initial begin
    rst = 1'b1;
    req = '0;
    a_bus = '0;
    b_bus = '0;
    tick();
    tick();
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_ack", 32'(ack), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_result", 32'(result), 32'd0);
    end
    a_bus[7:0] = 8'hA5;
    b_bus[7:0] = 8'h0F;
    req = 4'b0001;
    tick();
    chk("single_exec_ack", 32'(ack), 32'd0);
    chk("single_exec_busy", 32'(busy), 32'd1);
    tick();
    chk_op("single", 2'd0, 8'hAA);
    req = 4'b0000;
    tick();
    chk("single_after_ack", 32'(ack), 32'd0);
    chk("single_after_busy", 32'(busy), 32'd0);
    chk("single_hold_result", 32'(result), 32'hAA);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_bus[i*8 +: 8] = 8'(i);
      b_bus[i*8 +: 8] = 8'hF0;
    end
    req = 4'b1111;
    begin
      logic [1:0] order [5];
      order = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      for (int n = 0; n < 5; n++) begin
        tick();
        chk("cont_exec_ack", 32'(ack), 32'd0);
        tick();
        chk_op("cont", order[n], 8'hF0 ^ 8'(order[n]));
        tick();
        chk("cont_idle_ack", 32'(ack), 32'd0);
      end
    end
    req = 4'b0100;
    tick();
    tick();
    chk_op("wrap_pre", 2'd2, 8'hF2);
    req = 4'b1001;
    tick();
    tick();
    tick();
    chk_op("wrap_first", 2'd3, 8'hF3);
    req = 4'b0001;
    tick();
    tick();
    tick();
    chk_op("wrap_second", 2'd0, 8'hF0);
    req = 4'b0010;
    tick();
    tick();
    chk("midop_exec_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("midop_rst_ack", 32'(ack), 32'd0);
    chk("midop_rst_busy", 32'(busy), 32'd0);
    chk("midop_rst_result", 32'(result), 32'd0);
    chk("midop_rst_id", 32'(result_id), 32'd0);
    tick();
    chk("midop_hold_ack", 32'(ack), 32'd0);
    rst = 1'b0;
    tick();
    chk("midop_regrant_exec", 32'(busy), 32'd1);
    tick();
    chk_op("midop_regrant", 2'd1, 8'hF1);
    req = 4'b0000;
    tick();
    chk("final_ack", 32'(ack), 32'd0);
    chk("final_busy", 32'(busy), 32'd0);
`ifdef XOR_SHARE_STATS_EN
    chk("op_count", 32'(op_count), 32'd1);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/xor_share_arbiter.md
Name: xor_share_arbiter

Overview:
- Time-shares one registered XOR datapath between NREQ requesters, each presenting two WIDTH-bit operands.
- A round-robin arbiter picks one requester, latches its operands, computes a^b, and returns the result with a one-cycle ack tagged by requester id.
- Sits between client blocks and the team's XOR logic unit; it is the only block that drives that unit.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, operand/result width in bits.
- IDW, 2, requester id width; must equal ceil(log2(NREQ)).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester request, level; held until ack.
- a_bus  input  NREQ*WIDTH  operand a; requester i uses bits [i*WIDTH +: WIDTH].
- b_bus  input  NREQ*WIDTH  operand b, same packing.
- ack  output  NREQ  one-hot, one-cycle completion pulse.
- result  output  WIDTH  a^b of the acked request; valid while ack != 0.
- result_id  output  IDW  index of the acked requester.
- busy  output  1  high in EXEC and RESP.

Behaviour:
- Reset (async, immediate): state=IDLE, rr_ptr=0, ack=0, result=0, result_id=0, busy=0, operand latches=0. Reset mid-operation discards the in-flight op; no ack is issued.
- FSM: IDLE -> EXEC -> RESP -> IDLE. All outputs are registered.
- IDLE: if req != 0, pick the winner by round-robin and latch a/b of the winner plus its id. Go to EXEC. Otherwise stay in IDLE.
- Round-robin: search order starts at rr_ptr, then rr_ptr+1, wrapping mod NREQ. The first set req bit wins. On grant, rr_ptr = (winner+1) mod NREQ; wrap from NREQ-1 goes to 0.
- EXEC: result <= a_lat ^ b_lat, result_id <= id, ack <= one-hot(id). Go to RESP.
- RESP: ack is high for this single cycle. At exit, ack <= 0 and result holds its value. Go to IDLE.
- Latency: req sampled high in cycle T (IDLE), ack high in cycle T+2. Throughput is one op per 3 cycles.
- Requester rule: drop req on the clock edge where it samples its ack bit high. The arbiter samples req again in the following IDLE cycle, so there is no double grant.
- req or operand changes during EXEC/RESP are ignored, because operands are already latched. An op whose req was withdrawn still completes and acks.
- Simultaneous requests: exactly one grant per IDLE cycle. Losers wait; they are never dropped.
- Starvation bound: a held req is acked within 3*NREQ cycles.
- busy=1 exactly in EXEC and RESP.

Optional Feature:
- Macro XOR_SHARE_STATS_EN.
- Defined: adds output port op_count (16 bits). Reset value 0. Increments by 1 in every RESP cycle and wraps 0xFFFF -> 0x0000.
- Undefined: the port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then req=0 for 10 cycles -> ack=0, busy=0, result=0 throughout.
- Single request: req=4'b0001, a0=8'hA5, b0=8'h0F -> 2 cycles later ack=4'b0001, result=8'hAA, result_id=0, for exactly 1 cycle.
- Contention: all four req high with a_i=i, b_i=8'hF0 held -> acks in order 0,1,2,3,0, each 3 cycles apart, with result=8'hF0^i.
- Wrap: rr_ptr at 3 after granting 2, then req=4'b1001 -> id 3 is acked first, then id 0.
- Reset mid-op: assert rst during EXEC -> no ack pulse, all outputs 0 immediately. After release, a held req is re-granted and acked normally.
- Stats (XOR_SHARE_STATS_EN): run 65537 ops -> op_count=1 (wrapped). With the macro undefined, the bench compiles without the port.
